// File: rtl/nibble_add_pkg.sv
// Shared types and helpers for the nibble-serial adder controller and its slice.
package nibble_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NIB_W = 4;

  // Signed overflow: carry into the MSB disagrees with carry out of the MSB.
  function automatic logic signed_ovf(input logic c_msb_in, input logic c_out);
    return c_msb_in ^ c_out;
  endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit ripple-carry slice; also exposes the carry into bit 3.
module nibble_add_slice
  import nibble_add_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  always_comb begin : p_ripple
    logic c;
    c        = ci;
    s        = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < int'(NIB_W); i++) begin
      if (i == int'(NIB_W) - 1) c_msb_in = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder with valid/ready operand and result handshakes.
// Optional SUBTRACT_EN macro adds a 'sub' port selecting a - b.
module nibble_serial_add_ctrl
  import nibble_add_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NIBBLES = WIDTH / NIB_W;
  localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if ((WIDTH < NIB_W) || ((WIDTH % NIB_W) != 0)) begin : g_bad_width
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d, b_sh_q, b_sh_d, sum_sh_q, sum_sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d, ovf_q, ovf_d;
  logic               start_ready_q, start_ready_d, res_valid_q, res_valid_d;
  logic               busy_q, busy_d;
  logic [NIB_W-1:0]   slice_s;
  logic               slice_co, slice_cm, last_nib;

  nibble_add_slice u_slice (
    .x        (a_sh_q[NIB_W-1:0]),
    .y        (b_sh_q[NIB_W-1:0]),
    .ci       (carry_q),
    .s        (slice_s),
    .co       (slice_co),
    .c_msb_in (slice_cm)
  );

  assign last_nib = (cnt_q == CNT_W'(NIBBLES - 1));

  // State and all registered outputs / datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      a_sh_q        <= '0;
      b_sh_q        <= '0;
      sum_sh_q      <= '0;
      cnt_q         <= '0;
      carry_q       <= 1'b0;
      sum_q         <= '0;
      cout_q        <= 1'b0;
      ovf_q         <= 1'b0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_sh_q        <= a_sh_d;
      b_sh_q        <= b_sh_d;
      sum_sh_q      <= sum_sh_d;
      cnt_q         <= cnt_d;
      carry_q       <= carry_d;
      sum_q         <= sum_d;
      cout_q        <= cout_d;
      ovf_q         <= ovf_d;
      start_ready_q <= start_ready_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid) state_d = RUN;
      RUN:     if (last_nib) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, per-nibble shift and final result capture.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
`ifdef SUBTRACT_EN
          if (sub) begin
            b_sh_d  = ~b;
            carry_d = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        sum_sh_d = (sum_sh_q >> NIB_W) | (WIDTH'(slice_s) << (WIDTH - NIB_W));
        a_sh_d   = a_sh_q >> NIB_W;
        b_sh_d   = b_sh_q >> NIB_W;
        carry_d  = slice_co;
        if (last_nib) begin
          sum_d  = sum_sh_d;
          cout_d = slice_co;
          ovf_d  = signed_ovf(slice_cm, slice_co);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Handshake/status flags follow the next state so they line up with it.
  always_comb begin
    start_ready_d = (state_d == IDLE);
    res_valid_d   = (state_d == DONE);
    busy_d        = (state_d != IDLE);
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign busy        = busy_q;
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;

endmodule
